// File: rtl/motion_pkg.sv
// Shared types and defaults for the multi-channel motion detector.
// Optional feature macro used by this block: MOTION_PEAK_EN.
package motion_pkg;

  typedef enum logic [1:0] {
    QUIET    = 2'd0,
    ARMING   = 2'd1,
    MOVING   = 2'd2,
    SETTLING = 2'd3
  } motion_state_t;

  localparam int MOTION_WIDTH_D    = 12;
  localparam int MOTION_CHANNELS_D = 3;
  localparam int MOTION_ENTER_D    = 2;
  localparam int MOTION_EXIT_D     = 4;

  // Larger of the two debounce counts; sizes the shared counter.
  function automatic int unsigned max_cnt(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/motion_axis_delta.sv
// One channel: previous-sample register, signed step, magnitude and threshold compare.
// With MOTION_PEAK_EN defined the magnitude is also exported for peak tracking.
module motion_axis_delta
  import motion_pkg::*;
#(
  parameter int WIDTH = MOTION_WIDTH_D
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_value,
  input  logic [WIDTH-1:0] i_threshold,
`ifdef MOTION_PEAK_EN
  output logic [WIDTH-1:0] o_mag,
`endif
  output logic             o_active
);

  logic [WIDTH-1:0]        r_last;
  logic signed [WIDTH:0]   w_delta;
  logic [WIDTH-1:0]        w_mag;

  // |value - last|: the true magnitude never exceeds 2^WIDTH-1, so negating the
  // low WIDTH bits of a negative step yields it exactly.
  always_comb begin
    w_delta = $signed({i_value[WIDTH-1], i_value}) - $signed({r_last[WIDTH-1], r_last});
    w_mag   = w_delta[WIDTH] ? (~w_delta[WIDTH-1:0] + 1'b1) : w_delta[WIDTH-1:0];
  end

  assign o_active = (w_mag > i_threshold);
`ifdef MOTION_PEAK_EN
  assign o_mag = w_mag;
`endif

  // Remember every valid sample, including the priming one.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_last <= '0;
    end else if (i_load) begin
      r_last <= i_value;
    end
  end

endmodule

// File: rtl/motion_detector_multi.sv
// Multi-channel motion detector: priming, debounce FSM, start/end pulses.
// Define MOTION_PEAK_EN to add the peak_mag output.
module motion_detector_multi
  import motion_pkg::*;
#(
  parameter int WIDTH     = MOTION_WIDTH_D,
  parameter int CHANNELS  = MOTION_CHANNELS_D,
  parameter int ENTER_CNT = MOTION_ENTER_D,
  parameter int EXIT_CNT  = MOTION_EXIT_D
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      sample_valid,
  input  logic [CHANNELS*WIDTH-1:0] sample_data,
  input  logic [WIDTH-1:0]          threshold,
  output logic [CHANNELS-1:0]       active_mask,
  output logic                      moving,
  output logic                      motion_start,
`ifdef MOTION_PEAK_EN
  output logic [WIDTH-1:0]          peak_mag,
`endif
  output logic                      motion_end
);

  localparam int CW = $clog2(max_cnt(ENTER_CNT, EXIT_CNT) + 1);
  localparam logic [CW-1:0] ENTER_V = CW'(ENTER_CNT);
  localparam logic [CW-1:0] EXIT_V  = CW'(EXIT_CNT);

  motion_state_t       r_state;
  logic [CW-1:0]       r_cnt;
  logic                r_primed;
  logic [CHANNELS-1:0] r_active_mask;
  logic                r_moving;
  logic                r_motion_start;
  logic                r_motion_end;

  logic [CHANNELS-1:0] w_active;
  logic                w_any;
  logic [CW-1:0]       w_cnt_inc;
  logic                w_start_cond;
`ifdef MOTION_PEAK_EN
  logic [WIDTH-1:0]    w_mag [CHANNELS];
  logic [WIDTH-1:0]    w_max_mag;
  logic [WIDTH-1:0]    r_peak;
`endif

  for (genvar k = 0; k < CHANNELS; k++) begin : g_axis
    motion_axis_delta #(.WIDTH(WIDTH)) u_axis (
      .clk         (clk),
      .rst         (rst),
      .i_load      (sample_valid),
      .i_value     (sample_data[k*WIDTH +: WIDTH]),
      .i_threshold (threshold),
`ifdef MOTION_PEAK_EN
      .o_mag       (w_mag[k]),
      .o_active    (w_active[k])
`else
      .o_active    (w_active[k])
`endif
    );
  end

  assign w_any        = |w_active;
  assign w_cnt_inc    = r_cnt + 1'b1;
  assign w_start_cond = w_any && (((r_state == QUIET) && (ENTER_CNT == 1)) ||
                                  ((r_state == ARMING) && (w_cnt_inc == ENTER_V)));

  // Debounce FSM with registered mask, moving flag and one-cycle event pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state        <= QUIET;
      r_cnt          <= '0;
      r_primed       <= 1'b0;
      r_active_mask  <= '0;
      r_moving       <= 1'b0;
      r_motion_start <= 1'b0;
      r_motion_end   <= 1'b0;
    end else begin
      r_motion_start <= 1'b0;
      r_motion_end   <= 1'b0;
      if (sample_valid) begin
        if (!r_primed) begin
          r_primed      <= 1'b1;
          r_active_mask <= '0;
        end else begin
          r_active_mask <= w_active;
          unique case (r_state)
            QUIET: begin
              if (w_start_cond) begin
                r_state        <= MOVING;
                r_moving       <= 1'b1;
                r_motion_start <= 1'b1;
              end else if (w_any) begin
                r_state <= ARMING;
                r_cnt   <= CW'(1);
              end
            end
            ARMING: begin
              if (w_start_cond) begin
                r_state        <= MOVING;
                r_moving       <= 1'b1;
                r_motion_start <= 1'b1;
                r_cnt          <= '0;
              end else if (w_any) begin
                r_cnt <= w_cnt_inc;
              end else begin
                r_state <= QUIET;
                r_cnt   <= '0;
              end
            end
            MOVING: begin
              if (!w_any) begin
                if (EXIT_CNT == 1) begin
                  r_state      <= QUIET;
                  r_moving     <= 1'b0;
                  r_motion_end <= 1'b1;
                end else begin
                  r_state <= SETTLING;
                  r_cnt   <= CW'(1);
                end
              end
            end
            SETTLING: begin
              if (w_any) begin
                r_state <= MOVING;
                r_cnt   <= '0;
              end else if (w_cnt_inc == EXIT_V) begin
                r_state      <= QUIET;
                r_moving     <= 1'b0;
                r_motion_end <= 1'b1;
                r_cnt        <= '0;
              end else begin
                r_cnt <= w_cnt_inc;
              end
            end
            default: begin
              r_state <= QUIET;
              r_cnt   <= '0;
            end
          endcase
        end
      end
    end
  end

  assign active_mask  = r_active_mask;
  assign moving       = r_moving;
  assign motion_start = r_motion_start;
  assign motion_end   = r_motion_end;

`ifdef MOTION_PEAK_EN
  // Largest channel magnitude of the current sample.
  always_comb begin
    w_max_mag = '0;
    for (int unsigned k = 0; k < CHANNELS; k++) begin
      if (w_mag[k] > w_max_mag) w_max_mag = w_mag[k];
    end
  end

  // Peak loads on entry, tracks the maximum while moving, holds otherwise.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_peak <= '0;
    end else if (sample_valid && r_primed) begin
      if (w_start_cond) begin
        r_peak <= w_max_mag;
      end else if (r_moving && (w_max_mag > r_peak)) begin
        r_peak <= w_max_mag;
      end
    end
  end

  assign peak_mag = r_peak;
`else
  // Peak tracking not built.
`endif

endmodule
